// File: rtl/platform_collision.sv
// Sprite-vs-level contact query: scans 10 fixed rectangles one per clock, registered result.
// Latency: DONE 11 cycles after the accept cycle; one request in flight, result held until resp_ready.
module platform_collision #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [9:0] req_x,
  input  logic [9:0] req_y,
  output logic       req_ready,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       on_ground,
  output logic       hit_ceiling,
  output logic       wall_left,
  output logic       wall_right,
  output logic       overlap,
  output logic [9:0] ground_y
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } rect_t;

  // Same geometry the platform renderer draws.
  function automatic rect_t rect_at(input logic [3:0] i);
    case (i)
      4'd0:    rect_at = '{10'd16,  10'd159, 10'd132, 10'd147};
      4'd1:    rect_at = '{10'd480, 10'd623, 10'd132, 10'd147};
      4'd2:    rect_at = '{10'd81,  10'd560, 10'd215, 10'd230};
      4'd3:    rect_at = '{10'd16,  10'd255, 10'd298, 10'd313};
      4'd4:    rect_at = '{10'd384, 10'd623, 10'd298, 10'd313};
      4'd5:    rect_at = '{10'd113, 10'd528, 10'd381, 10'd396};
      4'd6:    rect_at = '{10'd0,   10'd639, 10'd464, 10'd479};
      4'd7:    rect_at = '{10'd0,   10'd639, 10'd0,   10'd15};
      4'd8:    rect_at = '{10'd0,   10'd15,  10'd0,   10'd479};
      4'd9:    rect_at = '{10'd624, 10'd639, 10'd0,   10'd479};
      default: rect_at = '{10'd0,   10'd0,   10'd0,   10'd0};
    endcase
  endfunction

  logic [1:0] state;
  logic [3:0] idx;
  logic [9:0] lat_x, lat_y;
  logic       acc_ground, acc_ceil, acc_wl, acc_wr, acc_ovl;
  logic [9:0] acc_gy;

  rect_t       rect;
  logic [10:0] sx0, sx1, sy0, sy1, rx0, rx1, ry0, ry1;
  logic        hov, vov, hit_g, hit_c, hit_wl, hit_wr, hit_o;
  logic        nxt_ground, nxt_ceil, nxt_wl, nxt_wr, nxt_ovl;
  logic [9:0]  nxt_gy;

  // 11-bit sums so the sprite's far edge never wraps.
  always_comb begin
    rect   = rect_at(idx);
    sx0    = {1'b0, lat_x};
    sy0    = {1'b0, lat_y};
    sx1    = sx0 + 11'(SPR_W - 1);
    sy1    = sy0 + 11'(SPR_H - 1);
    rx0    = {1'b0, rect.x0};
    rx1    = {1'b0, rect.x1};
    ry0    = {1'b0, rect.y0};
    ry1    = {1'b0, rect.y1};
    hov    = (sx0 <= rx1) && (sx1 >= rx0);
    vov    = (sy0 <= ry1) && (sy1 >= ry0);
    hit_g  = hov && (sy1 + 11'd1 == ry0);
    hit_c  = hov && (sy0 == ry1 + 11'd1);
    hit_wl = vov && (sx0 == rx1 + 11'd1);
    hit_wr = vov && (sx1 + 11'd1 == rx0);
    hit_o  = hov && vov;
    nxt_ground = acc_ground | hit_g;
    nxt_ceil   = acc_ceil   | hit_c;
    nxt_wl     = acc_wl     | hit_wl;
    nxt_wr     = acc_wr     | hit_wr;
    nxt_ovl    = acc_ovl    | hit_o;
    // First (lowest-index) ground contact wins.
    nxt_gy     = (hit_g && !acc_ground) ? rect.y0 : acc_gy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 4'd0;
      lat_x       <= 10'd0;
      lat_y       <= 10'd0;
      acc_ground  <= 1'b0;
      acc_ceil    <= 1'b0;
      acc_wl      <= 1'b0;
      acc_wr      <= 1'b0;
      acc_ovl     <= 1'b0;
      acc_gy      <= 10'h3FF;
      on_ground   <= 1'b0;
      hit_ceiling <= 1'b0;
      wall_left   <= 1'b0;
      wall_right  <= 1'b0;
      overlap     <= 1'b0;
      ground_y    <= 10'h3FF;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_x      <= req_x;
            lat_y      <= req_y;
            acc_ground <= 1'b0;
            acc_ceil   <= 1'b0;
            acc_wl     <= 1'b0;
            acc_wr     <= 1'b0;
            acc_ovl    <= 1'b0;
            acc_gy     <= 10'h3FF;
            idx        <= 4'd0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          acc_ground <= nxt_ground;
          acc_ceil   <= nxt_ceil;
          acc_wl     <= nxt_wl;
          acc_wr     <= nxt_wr;
          acc_ovl    <= nxt_ovl;
          acc_gy     <= nxt_gy;
          if (idx == 4'd9) begin
            on_ground   <= nxt_ground;
            hit_ceiling <= nxt_ceil;
            wall_left   <= nxt_wl;
            wall_right  <= nxt_wr;
            overlap     <= nxt_ovl;
            ground_y    <= nxt_gy;
            state       <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_platform_collision.sv
// Randomized bench for platform_collision against a rectangle-list reference model.
module tb_platform_collision;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [9:0] req_x = 10'd0;
  logic [9:0] req_y = 10'd0;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic       on_ground, hit_ceiling, wall_left, wall_right, overlap;
  logic [9:0] ground_y;
  logic [14:0] res;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle_cnt = 0;

  int RX0 [10] = '{16, 480, 81,  16,  384, 113, 0,   0,   0,   624};
  int RX1 [10] = '{159, 623, 560, 255, 623, 528, 639, 639, 15,  639};
  int RY0 [10] = '{132, 132, 215, 298, 298, 381, 464, 0,   0,   0};
  int RY1 [10] = '{147, 147, 230, 313, 313, 396, 479, 15,  479, 479};

  platform_collision #(.SPR_W(16), .SPR_H(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .on_ground(on_ground), .hit_ceiling(hit_ceiling), .wall_left(wall_left),
    .wall_right(wall_right), .overlap(overlap), .ground_y(ground_y)
  );

  assign res = {on_ground, hit_ceiling, wall_left, wall_right, overlap, ground_y};

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result packed as {ground, ceiling, wall_left, wall_right, overlap, ground_y}.
  function automatic logic [14:0] model(input int x, input int y);
    bit g = 0, c = 0, l = 0, r = 0, o = 0;
    int gy = 1023;
    for (int i = 0; i < 10; i++) begin
      bit h, v;
      h = (x <= RX1[i]) && (x + 15 >= RX0[i]);
      v = (y <= RY1[i]) && (y + 15 >= RY0[i]);
      if (h && (y + 16 == RY0[i])) begin
        if (!g) gy = RY0[i];
        g = 1;
      end
      if (h && (y == RY1[i] + 1)) c = 1;
      if (v && (x == RX1[i] + 1)) l = 1;
      if (v && (x + 16 == RX0[i])) r = 1;
      if (h && v) o = 1;
    end
    return {g, c, l, r, o, 10'(gy)};
  endfunction

  // Positions biased to sit flush against a random rectangle edge.
  task automatic pick(output logic [9:0] x, output logic [9:0] y);
    int r, xx, yy;
    r = int'($urandom_range(0, 9));
    case ($urandom_range(0, 4))
      0: begin yy = RY0[r] - 16; xx = int'($urandom_range(RX0[r], RX1[r])) - int'($urandom_range(0, 15)); end
      1: begin yy = RY1[r] + 1;  xx = int'($urandom_range(RX0[r], RX1[r])) - int'($urandom_range(0, 15)); end
      2: begin xx = RX1[r] + 1;  yy = int'($urandom_range(RY0[r], RY1[r])) - int'($urandom_range(0, 15)); end
      3: begin xx = RX0[r] - 16; yy = int'($urandom_range(RY0[r], RY1[r])) - int'($urandom_range(0, 15)); end
      default: begin xx = int'($urandom_range(0, 1023)); yy = int'($urandom_range(0, 1023)); end
    endcase
    if (xx < 0) xx = 0;
    if (yy < 0) yy = 0;
    if (xx > 1023) xx = 1023;
    if (yy > 1023) yy = 1023;
    x = 10'(xx);
    y = 10'(yy);
  endtask

  task automatic start_req(input logic [9:0] x, input logic [9:0] y, input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready"}, req_ready, 1);
    req_x = x; req_y = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_x = 10'($urandom);
    req_y = 10'($urandom);
  endtask

  // Counts cycles with the accept cycle as cycle 0; DONE must be cycle 11.
  task automatic wait_resp(input logic [14:0] exp, input string tag);
    int cyc = 1;
    while (!resp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check({tag, "_lat"}, cyc, 11);
    check({tag, "_res"}, res, exp);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic [9:0] x, input logic [9:0] y, input logic [14:0] exp, input string tag);
    start_req(x, y, tag);
    wait_resp(exp, tag);
    consume();
  endtask

  initial begin
    logic [9:0] rx, ry;
    logic [14:0] held, exp;
    logic [14:0] q[$];
    int acc_cnt, last_acc, it;
    logic acc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_result", res, 15'h03FF);
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", req_ready, 1);

    do_req(10'd32,  10'd116, {5'b10000, 10'd132}, "ground_a");
    do_req(10'd16,  10'd148, {5'b01100, 10'h3FF}, "ceil_wall");
    do_req(10'd608, 10'd200, {5'b00010, 10'h3FF}, "wall_right");
    do_req(10'd100, 10'd220, {5'b00001, 10'h3FF}, "inside_c");
    do_req(10'd300, 10'd100, {5'b00000, 10'h3FF}, "free_air");

    // Hold DONE with resp_ready low while new requests are offered.
    start_req(10'd32, 10'd116, "hold");
    held = {5'b10000, 10'd132};
    wait_resp(held, "hold");
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_x = 10'($urandom);
      req_y = 10'($urandom);
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_res", res, held);
    end
    req_valid = 1'b0;
    consume();
    check("hold_no_queue", resp_valid, 0);
    check("hold_idle_ready", req_ready, 1);

    // Reset mid-scan.
    start_req(10'd16, 10'd148, "rst_mid");
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", resp_valid, 0);
    check("rst_mid_res", res, 15'h03FF);
    check("rst_mid_ready", req_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_release_ready", req_ready, 1);
    do_req(10'd608, 10'd200, {5'b00010, 10'h3FF}, "after_rst");

    for (int i = 0; i < 30; i++) begin
      pick(rx, ry);
      do_req(rx, ry, model(int'(rx), int'(ry)), "rand");
    end

    // Back-to-back: both handshakes tied high.
    acc_cnt = 0; last_acc = -1; it = 0;
    resp_ready = 1'b1;
    pick(rx, ry);
    req_x = rx; req_y = ry;
    req_valid = 1'b1;
    while (acc_cnt < 6 && it < 200) begin
      @(negedge clk);
      acc = 1'b0;
      if (resp_valid) begin
        exp = 15'h7FFF;
        if (q.size() > 0) exp = q.pop_front();
        check("b2b_res", res, exp);
      end
      if (req_ready) begin
        acc = 1'b1;
        q.push_back(model(int'(req_x), int'(req_y)));
        if (last_acc >= 0) check("b2b_period", cycle_cnt - last_acc, 12);
        last_acc = cycle_cnt;
        acc_cnt++;
      end
      it++;
      @(posedge clk); #1;
      if (acc) begin
        pick(rx, ry);
        req_x = rx; req_y = ry;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc_cnt, 6);
    it = 0;
    while (q.size() > 0 && it < 40) begin
      @(negedge clk);
      if (resp_valid) check("b2b_res", res, q.pop_front());
      it++;
    end
    check("b2b_drain", q.size(), 0);
    resp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
